// File: rtl/chart_pkg.sv
// Shared types and constants for the chart sequencer.
// Holds the state encoding, the end-of-chart marker and the chart entry layout.
package chart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CHART_LANES    = 4;
  localparam int CHART_TIMING_W = 4;

  typedef struct packed {
    logic [CHART_LANES-1:0]    arrows;
    logic [CHART_TIMING_W-1:0] timing;
  } entry_t;

  localparam logic [CHART_TIMING_W-1:0] CHART_END = '1;

  // All-ones marker for an arbitrary timing width (up to 32 bits).
  function automatic logic [31:0] chart_end(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one synchronous write port and one enabled synchronous read port.
// A read and a write to the same address in one cycle returns the old contents.
module ram_1r1w_sync #(
  parameter int    WIDTH_P     = 8,
  parameter int    DEPTH_P     = 256,
  parameter string INIT_FILE_P = ""
) (
  input  logic                       clk_i,
  input  logic                       wr_valid_i,
  input  logic [$clog2(DEPTH_P)-1:0] wr_addr_i,
  input  logic [WIDTH_P-1:0]         wr_data_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(DEPTH_P)-1:0] rd_addr_i,
  output logic [WIDTH_P-1:0]         rd_data_o
);

  logic [WIDTH_P-1:0] r_mem [DEPTH_P];
  logic [WIDTH_P-1:0] r_rd_data;

  // Contents arrive through the write port; INIT_FILE_P is carried for the FPGA memory macro.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/chart_player.sv
// Multi-song chart sequencer: plays one song entry at a time under a valid/next handshake,
// stopping or looping when it hits the end marker or the last slot of the song.
module chart_player
  import chart_pkg::*;
#(
  parameter int    LANES_P        = 4,
  parameter int    TIMING_WIDTH_P = 4,
  parameter int    SONG_DEPTH_P   = 128,
  parameter int    SONGS_P        = 2,
  parameter string INIT_FILE_P    = ""
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic [((SONGS_P > 1) ? $clog2(SONGS_P) : 1)-1:0] song_i,
  input  logic                                          start_i,
  input  logic                                          stop_i,
  input  logic                                          loop_i,
  input  logic                                          next_i,
  input  logic                                          wr_valid_i,
  input  logic [$clog2(SONGS_P*SONG_DEPTH_P)-1:0]       wr_addr_i,
  input  logic [LANES_P+TIMING_WIDTH_P-1:0]             wr_data_i,
  output logic                                          valid_o,
  output logic [LANES_P-1:0]                            arrows_o,
  output logic [TIMING_WIDTH_P-1:0]                     timing_o,
  output logic [$clog2(SONG_DEPTH_P)-1:0]               index_o,
  output logic                                          done_o
);

  localparam int IDX_W  = $clog2(SONG_DEPTH_P);
  localparam int SONG_W = (SONGS_P > 1) ? $clog2(SONGS_P) : 1;
  localparam int ADDR_W = $clog2(SONGS_P*SONG_DEPTH_P);
  localparam int DATA_W = LANES_P + TIMING_WIDTH_P;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_FETCH = 2'(FETCH);
  localparam logic [1:0] S_PLAY  = 2'(PLAY);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  localparam logic [TIMING_WIDTH_P-1:0] END_MARK   = TIMING_WIDTH_P'(chart_end(TIMING_WIDTH_P));
  localparam logic [IDX_W-1:0]          LAST_INDEX = IDX_W'(SONG_DEPTH_P - 1);

  logic [1:0]        r_state;
  logic [SONG_W-1:0] r_song;
  logic              r_loop;
  logic [IDX_W-1:0]  r_index;

  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_marker;
  logic              w_last;
  logic              w_valid;

  // The index never carries into the song field; single-song builds drop the song bits.
  generate
    if (SONGS_P > 1) begin : g_multi_song
      assign w_rd_addr = {r_song, r_index};
    end else begin : g_single_song
      assign w_rd_addr = r_index;
    end
  endgenerate

  ram_1r1w_sync #(
    .WIDTH_P    (DATA_W),
    .DEPTH_P    (SONGS_P*SONG_DEPTH_P),
    .INIT_FILE_P(INIT_FILE_P)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_valid_i(wr_valid_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (r_state == S_FETCH),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_rd_data)
  );

  assign w_marker = (w_rd_data[TIMING_WIDTH_P-1:0] == END_MARK);
  assign w_last   = (r_index == LAST_INDEX);
  assign w_valid  = (r_state == S_PLAY) && !w_marker;

  // A marker ends the song on its own; a real entry in the last slot ends it once popped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_song  <= '0;
      r_loop  <= 1'b0;
      r_index <= '0;
    end else if (stop_i) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_song  <= song_i;
            r_loop  <= loop_i;
            r_index <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_PLAY;
        S_PLAY: begin
          if (w_marker || (w_last && next_i)) begin
            if (r_loop) begin
              r_index <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_DONE;
            end
          end else if (next_i) begin
            r_index <= r_index + 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o  = w_valid;
  assign arrows_o = w_valid ? w_rd_data[DATA_W-1:TIMING_WIDTH_P] : '0;
  assign timing_o = w_valid ? w_rd_data[TIMING_WIDTH_P-1:0] : '0;
  assign index_o  = r_index;
  assign done_o   = (r_state == S_DONE);

endmodule

// File: tb/tb_chart_player.sv
// Self-checking bench for chart_player (8-entry songs, 2 songs): directed scenarios followed by
// randomized traffic, every cycle compared against a playback model of the song rules.
module tb_chart_player;

  localparam int DEPTH = 8;
  localparam int SONGS = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       song_i;
  logic       start_i;
  logic       stop_i;
  logic       loop_i;
  logic       next_i;
  logic       wr_valid_i;
  logic [3:0] wr_addr_i;
  logic [7:0] wr_data_i;
  logic       valid_o;
  logic [3:0] arrows_o;
  logic [3:0] timing_o;
  logic [2:0] index_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  // Model: chart memory plus playback position of the selected song.
  logic [7:0] mMem [16];
  logic       mActive;
  logic       mFetching;
  logic       mDone;
  logic       mLoop;
  logic       mSong;
  logic [2:0] mIdx;
  logic [7:0] mEntry;

  always #5 clk_i = ~clk_i;

  chart_player #(
    .LANES_P       (4),
    .TIMING_WIDTH_P(4),
    .SONG_DEPTH_P  (DEPTH),
    .SONGS_P       (SONGS),
    .INIT_FILE_P   ("")
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .song_i    (song_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .loop_i    (loop_i),
    .next_i    (next_i),
    .wr_valid_i(wr_valid_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .valid_o   (valid_o),
    .arrows_o  (arrows_o),
    .timing_o  (timing_o),
    .index_o   (index_o),
    .done_o    (done_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the playback rules, seen from the consumer's side.
  task automatic modelStep(input logic rs, input logic st, input logic sp, input logic nx,
                           input logic sg, input logic lp, input logic wv,
                           input logic [3:0] wa, input logic [7:0] wd);
    logic songOver;
    if (rs) begin
      mActive = 1'b0; mFetching = 1'b0; mDone = 1'b0;
      mLoop = 1'b0; mSong = 1'b0; mIdx = 3'd0; mEntry = 8'h00;
    end else if (sp) begin
      mActive = 1'b0; mFetching = 1'b0; mDone = 1'b0; mIdx = 3'd0;
    end else if (!mActive) begin
      if (st) begin
        mActive = 1'b1; mFetching = 1'b1; mDone = 1'b0;
        mSong = sg; mLoop = lp; mIdx = 3'd0;
      end
    end else if (mFetching) begin
      mEntry = mMem[{mSong, mIdx}];
      mFetching = 1'b0;
    end else begin
      songOver = (mEntry[3:0] == 4'hF) || (nx && (int'(mIdx) == DEPTH - 1));
      if (songOver && mLoop) begin
        mIdx = 3'd0; mFetching = 1'b1;
      end else if (songOver) begin
        mActive = 1'b0; mDone = 1'b1;
      end else if (nx) begin
        mIdx = mIdx + 3'd1; mFetching = 1'b1;
      end
    end
    if (wv) mMem[wa] = wd;
  endtask

  task automatic checkAll();
    logic expValid;
    expValid = mActive && !mFetching && (mEntry[3:0] != 4'hF);
    checkOutput("valid_o", 32'(valid_o), 32'(expValid));
    checkOutput("arrows_o", 32'(arrows_o), expValid ? 32'(mEntry[7:4]) : 32'd0);
    checkOutput("timing_o", 32'(timing_o), expValid ? 32'(mEntry[3:0]) : 32'd0);
    checkOutput("index_o", 32'(index_o), 32'(mIdx));
    checkOutput("done_o", 32'(done_o), 32'(mDone));
  endtask

  task automatic applyStimulus(input logic rs, input logic st, input logic sp, input logic nx,
                               input logic sg, input logic lp, input logic wv,
                               input logic [3:0] wa, input logic [7:0] wd);
    reset_i = rs; start_i = st; stop_i = sp; next_i = nx;
    song_i = sg; loop_i = lp; wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd;
    @(posedge clk_i);
    modelStep(rs, st, sp, nx, sg, lp, wv, wa, wd);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input logic nx);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, nx, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic startSong(input logic sg, input logic lp, input logic nx);
    applyStimulus(1'b0, 1'b1, 1'b0, nx, sg, lp, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    logic [7:0] song1 [8];
    logic [7:0] d;
    song1 = '{8'h13, 8'h22, 8'h41, 8'h0F, 8'hA4, 8'hB5, 8'hC6, 8'hD7};
    for (int a = 0; a < 16; a++) mMem[a] = 8'h00;

    // Reset, then next pulses while idle must not move the index.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    idleCycles(3, 1'b1);

    // Song 0: eight real entries, no marker. Song 1: three entries then a marker.
    for (int a = 0; a < 16; a++) begin
      d = (a < 8) ? {4'(a + 1), 4'(a)} : song1[a - 8];
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a), d);
    end

    $display("[TB] song 1, no loop, consumer always ready");
    startSong(1'b1, 1'b0, 1'b1);
    idleCycles(12, 1'b1);

    $display("[TB] song 1, loop mode");
    startSong(1'b1, 1'b1, 1'b1);
    idleCycles(16, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);

    $display("[TB] consumer stall then full song 0");
    startSong(1'b0, 1'b0, 1'b0);
    idleCycles(22, 1'b0);
    idleCycles(1, 1'b1);
    idleCycles(5, 1'b0);
    idleCycles(20, 1'b1);

    $display("[TB] stop with start and next mid-song, then restart");
    startSong(1'b1, 1'b1, 1'b1);
    idleCycles(4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
    idleCycles(2, 1'b0);
    startSong(1'b1, 1'b0, 1'b1);
    idleCycles(10, 1'b1);

    $display("[TB] write colliding with the fetch of the same entry");
    startSong(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h9E);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    startSong(1'b0, 1'b0, 1'b0);
    idleCycles(3, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      d = 8'($urandom);
      if ($urandom_range(3) == 0) d[3:0] = 4'hF;
      applyStimulus(($urandom_range(199) == 0),
                    ($urandom_range(7) == 0),
                    ($urandom_range(29) == 0),
                    1'($urandom_range(1)),
                    1'($urandom_range(1)),
                    1'($urandom_range(1)),
                    ($urandom_range(5) == 0),
                    4'($urandom_range(15)),
                    d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chart_player.md
# chart_player

Multi-song, parametrised chart sequencer for the rhythm-game datapath. Stores `SONGS_P` charts of `SONG_DEPTH_P` entries each in one synchronous RAM. Each entry is `{arrows, timing}`. On `start_i` the block plays the selected song one entry at a time under a valid/next handshake, detects an end-of-chart marker, and either stops or loops. It sits between the chart loader (write port) and the arrow scroller/judge (read side).

## Interface
Parameters:
- `LANES_P`, 4: arrow lanes, i.e. width of `arrows_o`.
- `TIMING_WIDTH_P`, 4: width of `timing_o`.
- `SONG_DEPTH_P`, 128: entries per song; must be a power of two.
- `SONGS_P`, 2: number of songs; must be a power of two and ≥ 1.
- `INIT_FILE_P`, "": optional memory init file passed to the RAM.

Ports:
- One clock, `clk_i`; reset `reset_i` is synchronous and active-high.
- `clk_i` in, 1: clock.
- `reset_i` in, 1: sync active-high reset.
- `song_i` in, max(1,$clog2(SONGS_P)): song select, sampled only with an accepted `start_i`.
- `start_i` in, 1: begin playback; accepted in IDLE or DONE.
- `stop_i` in, 1: abort to IDLE from any state.
- `loop_i` in, 1: loop mode, sampled together with an accepted `start_i`.
- `next_i` in, 1: consumer pop; effective only while `valid_o`=1.
- `wr_valid_i` in, 1: loader write strobe.
- `wr_addr_i` in, $clog2(SONGS_P*SONG_DEPTH_P): loader address.
- `wr_data_i` in, LANES_P+TIMING_WIDTH_P: loader data, `{arrows, timing}`.
- `valid_o` out, 1: current entry is presented.
- `arrows_o` out, LANES_P: entry arrows; 0 when `valid_o`=0.
- `timing_o` out, TIMING_WIDTH_P: entry timing; 0 when `valid_o`=0.
- `index_o` out, $clog2(SONG_DEPTH_P): in-song index of the current/fetching entry.
- `done_o` out, 1: chart finished (non-loop mode).

## Operation
- States: IDLE, FETCH, PLAY, DONE.
- Reset values: state IDLE, `valid_o`=0, `done_o`=0, `index_o`=0, `arrows_o`/`timing_o`=0, song/loop registers=0.
- IDLE or DONE, `start_i`=1:
  - latch `song_i` and `loop_i`;
  - set index=0 and `done_o`=0;
  - go to FETCH.
- FETCH: RAM read is issued at address `{song, index}`. Next state is PLAY.
- PLAY:
  - `valid_o`=1; `arrows_o`/`timing_o` = RAM read data.
  - End condition: `timing` == all-ones (end marker, `CHART_END` from the package), or index == SONG_DEPTH_P-1 and the entry is not a marker.
  - End marker entry: `valid_o` stays 0; the entry is never presented.
  - Last-slot entry that is not a marker: presented normally; the end is handled when it is popped.
  - `next_i`=1 and not at end: index+1, go to FETCH.
  - At end with loop=1: index=0, go to FETCH.
  - At end with loop=0: go to DONE.
- DONE: `done_o`=1, held until an accepted `start_i`, `stop_i`, or reset.
- `stop_i`:
  - in any state, go to IDLE next cycle with `valid_o`=0 and `done_o`=0;
  - has priority over `start_i` and `next_i`.
- `start_i` in FETCH/PLAY is ignored; restarting requires `stop_i` first.
- Write port is independent of the FSM:
  - write to the address being read in the same cycle returns old data;
  - the new data is seen on the next fetch.
- Index arithmetic is unsigned and wraps modulo SONG_DEPTH_P only through the loop path; it never carries into the song field.

## Timing
- `start_i` sampled at edge N: FETCH during N..N+1, `valid_o`=1 after edge N+1 (2-cycle start latency).
- `next_i` sampled with `valid_o`=1 at edge M: `valid_o`=0 for one cycle, next entry valid after edge M+1.
  - Sustained throughput is 1 entry per 2 cycles.
- `arrows_o`/`timing_o` are stable while `valid_o`=1 and `next_i`=0. Holding is unbounded.
- End marker reached with loop=0: `done_o`=1 one cycle after the marker's read data returns.
- Reset mid-playback takes effect at the next edge, exactly as power-on reset.

## Structure
- `chart_pkg`:
  - `state_t` enum {IDLE, FETCH, PLAY, DONE};
  - `CHART_END` function/localparam = all-ones of TIMING_WIDTH_P;
  - `entry_t` packed struct {arrows, timing}.
- Sub-module: existing `ram_1r1w_sync`, width LANES_P+TIMING_WIDTH_P, depth SONGS_P*SONG_DEPTH_P, read address `{song_q, index_q}`.
- FSM and index counter live in `chart_player`; the existing `counter_up` is not reused because index needs load-zero.

## Test plan
- Reset then idle: after `reset_i` all outputs are 0. `next_i` pulses with `valid_o`=0 leave `index_o`=0.
- Song 1 holds 3 entries (`8'h13`, `8'h22`, `8'h41`) then `8'h0F`:
  - start with `song_i`=1, `loop_i`=0, `next_i` tied high;
  - expect valid entries 0x13, 0x22, 0x41 two cycles apart;
  - then `done_o`=1 and `valid_o`=0.
- Same chart with `loop_i`=1: after 0x41 and its pop, `index_o` returns to 0 and 0x13 reappears; `done_o` never asserts.
- Consumer stall: hold `next_i`=0 for 20 cycles in PLAY → outputs constant; one pulse advances exactly one entry.
- Full song with no marker (SONG_DEPTH_P=8 build):
  - entry 7 is presented;
  - its pop gives `done_o`=1;
  - song 0's address space is never read past index 7 into song 1.
- `stop_i` asserted together with `start_i` and `next_i` mid-song → IDLE next cycle, `valid_o`=0; restart from `start_i` replays from index 0.
